// File: rtl/subgraph_info_writer_pkg.sv
// Shared SPMM package for the per-subgraph info writer.
//   - writer FSM state encoding
//   - width helpers for NUM_NODE_W, OFFSET_W, ADDR_W, CNT_W and the record width
//   - record layout at the default parameter values
// Optional feature macro: SUBGRAPH_OFFSET_EN (appends the cumulative node offset
// in the MSBs of each record).
package subgraph_info_writer_pkg;

    localparam int DEF_NUM_SUBGRAPHS = 2708;
    localparam int DEF_MAX_NODES     = 168;
    localparam int DEF_TOTAL_NODES   = 13264;

`ifdef SUBGRAPH_OFFSET_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2,
        FULL  = 2'd3
    } sgw_state_e;

    function automatic int num_node_w(input int max_nodes);
        return $clog2(max_nodes + 1);
    endfunction

    function automatic int offset_w(input int total_nodes);
        return $clog2(total_nodes + 1);
    endfunction

    function automatic int addr_w(input int num_subgraphs);
        return (num_subgraphs > 1) ? $clog2(num_subgraphs) : 1;
    endfunction

    function automatic int cnt_w(input int num_subgraphs);
        return $clog2(num_subgraphs + 1);
    endfunction

    function automatic int din_w(input int max_nodes, input int total_nodes);
        return num_node_w(max_nodes) + (OFFSET_EN ? offset_w(total_nodes) : 0);
    endfunction

    // Record layout at default widths; the writer builds the same layout at
    // its own parameter widths.
`ifdef SUBGRAPH_OFFSET_EN
    typedef struct packed {
        logic [offset_w(DEF_TOTAL_NODES)-1:0] offset;
        logic [num_node_w(DEF_MAX_NODES)-1:0] num_node;
    } sgw_rec_t;
`else
    typedef struct packed {
        logic [num_node_w(DEF_MAX_NODES)-1:0] num_node;
    } sgw_rec_t;
`endif

endpackage

// File: rtl/subgraph_info_writer.sv
// Per-subgraph info writer for the SPMM stage.
// Captures num_node on every source beat (src_flag && spmm_vld_i) and writes one
// record per subgraph into the num-node BRAM at consecutive addresses, one record
// per cycle. Stops in FULL after NUM_SUBGRAPHS records; layer_start_i restarts.
// Optional feature macro: SUBGRAPH_OFFSET_EN -> record is {offset, num_node}
// where offset is the running node total before this subgraph.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   layer_start_i         clears address, count and offset; returns to IDLE
//   spmm_vld_i, src_flag  node beat valid / first node of a subgraph
//   num_node              node count, sampled on source beats
//   num_node_bram_*       BRAM write port (din, ena, addra)
//   subgraph_cnt_o        records written this layer
//   full_o                all records of the layer written
//   layer_done_o          pulse on entry to FULL
//   drop_o                pulse: source beat discarded while full
//   range_err_o           pulse in a write cycle with num_node 0 or > MAX_NODES
module subgraph_info_writer
    import subgraph_info_writer_pkg::*;
#(
    parameter int NUM_SUBGRAPHS = DEF_NUM_SUBGRAPHS,
    parameter int MAX_NODES     = DEF_MAX_NODES,
    parameter int TOTAL_NODES   = DEF_TOTAL_NODES,
    localparam int NUM_NODE_W   = num_node_w(MAX_NODES),
    localparam int ADDR_W       = addr_w(NUM_SUBGRAPHS),
    localparam int CNT_W        = cnt_w(NUM_SUBGRAPHS),
    localparam int DIN_W        = din_w(MAX_NODES, TOTAL_NODES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  layer_start_i,
    input  logic                  spmm_vld_i,
    input  logic                  src_flag,
    input  logic [NUM_NODE_W-1:0] num_node,
    output logic [DIN_W-1:0]      num_node_bram_din,
    output logic                  num_node_bram_ena,
    output logic [ADDR_W-1:0]     num_node_bram_addra,
    output logic [CNT_W-1:0]      subgraph_cnt_o,
    output logic                  full_o,
    output logic                  layer_done_o,
    output logic                  drop_o,
    output logic                  range_err_o
);

    sgw_state_e            state_q, state_d;
    logic [NUM_NODE_W-1:0] cap_q, cap_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  drop_q, drop_d;
    logic                  src_beat;
    logic                  last_rec;

`ifdef SUBGRAPH_OFFSET_EN
    localparam int OFFSET_W = offset_w(TOTAL_NODES);
    logic [OFFSET_W-1:0]   offset_q, offset_d;
`endif

    assign src_beat = src_flag && spmm_vld_i;
    assign last_rec = (cnt_q == CNT_W'(NUM_SUBGRAPHS - 1));

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        drop_d   = 1'b0;
`ifdef SUBGRAPH_OFFSET_EN
        offset_d = offset_q;
`endif
        if (layer_start_i) begin
            // The write decoded from WRITE this cycle still goes out at the old
            // address; only the bookkeeping restarts.
            state_d  = IDLE;
            addr_d   = '0;
            cnt_d    = '0;
`ifdef SUBGRAPH_OFFSET_EN
            offset_d = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE, WAIT: begin
                    if (src_beat) begin
                        cap_d   = num_node;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    addr_d   = addr_q + ADDR_W'(1);
                    cnt_d    = cnt_q + CNT_W'(1);
`ifdef SUBGRAPH_OFFSET_EN
                    offset_d = offset_q + OFFSET_W'(cap_q);
`endif
                    if (last_rec) begin
                        state_d = FULL;
                        done_d  = 1'b1;
                        drop_d  = src_beat;
                    end else if (src_beat) begin
                        cap_d   = num_node;
                    end else begin
                        state_d = WAIT;
                    end
                end
                FULL: begin
                    drop_d = src_beat;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cap_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
`ifdef SUBGRAPH_OFFSET_EN
            offset_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
`ifdef SUBGRAPH_OFFSET_EN
            offset_q <= offset_d;
`endif
        end
    end

    assign num_node_bram_ena   = (state_q == WRITE);
    assign num_node_bram_addra = addr_q;
`ifdef SUBGRAPH_OFFSET_EN
    assign num_node_bram_din   = {offset_q, cap_q};
`else
    assign num_node_bram_din   = cap_q;
`endif
    assign subgraph_cnt_o      = cnt_q;
    assign full_o              = (state_q == FULL);
    assign layer_done_o        = done_q;
    assign drop_o              = drop_q;
    assign range_err_o         = num_node_bram_ena &&
                                 ((cap_q == '0) || (cap_q > NUM_NODE_W'(MAX_NODES)));

endmodule
